// File: rtl/loader_pkg.sv
// loader_pkg: shared types and constants for the boot-time program loader
package loader_pkg;
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CSUM, S_RUN, S_ERROR
    } state_t;
    localparam int WORD_WIDTH = 16;
    localparam int HDR_BYTES = 2;
    localparam logic [7:0] CSUM_INIT = 8'h00;
endpackage

// File: rtl/loader_checksum.sv
// loader_checksum: running XOR of frame bytes with a compare against the incoming byte
module loader_checksum
    import loader_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       en,
    input  logic [7:0] data,
    output logic       match
);
    logic [7:0] acc;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) acc <= CSUM_INIT;
        else if (clear) acc <= CSUM_INIT;
        else if (en) acc <= acc ^ data;
    end
    assign match = data == acc;
endmodule

// File: rtl/program_loader.sv
// program_loader: receives a framed byte stream, writes instruction words and
// holds the CPU in reset until a checksum-verified image is in memory
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  imem_wr_en,
    output logic [ADDR_WIDTH-1:0] imem_wr_addr,
    output logic [WORD_WIDTH-1:0] imem_wr_data,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   word_count
);
    localparam logic [31:0] CAP = 32'(1) << ADDR_WIDTH;
    state_t state, state_n;
    logic [7:0] len_hi, hi;
    logic [ADDR_WIDTH:0] n_words;
    logic [8*HDR_BYTES-1:0] n_req;
    logic hs, go, last, match, bad_len;

    always_comb begin
        hs = rx_valid && rx_ready;
        go = start && (state == S_IDLE || state == S_RUN || state == S_ERROR);
        n_req = {len_hi, rx_data};
        bad_len = n_req == '0 || 32'(n_req) > CAP;
        last = word_count + (ADDR_WIDTH+1)'(1) == n_words;
        state_n = state;
        case (state)
            S_IDLE, S_RUN, S_ERROR: if (start) state_n = S_LEN_HI;
            S_LEN_HI:  if (hs) state_n = S_LEN_LO;
            S_LEN_LO:  if (hs) state_n = bad_len ? S_ERROR : S_DATA_HI;
            S_DATA_HI: if (hs) state_n = S_DATA_LO;
            S_DATA_LO: if (hs) state_n = last ? S_CSUM : S_DATA_HI;
            S_CSUM:    if (hs) state_n = match ? S_RUN : S_ERROR;
            default:   state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else state <= state_n;
    end

    // n_words only needs ADDR_WIDTH+1 bits once oversize lengths are rejected
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            len_hi <= '0;
            hi <= '0;
            n_words <= '0;
            word_count <= '0;
            imem_wr_en <= 1'b0;
            imem_wr_addr <= '0;
            imem_wr_data <= '0;
        end else begin
            imem_wr_en <= hs && state == S_DATA_LO;
            if (go) word_count <= '0;
            if (hs && state == S_LEN_HI) len_hi <= rx_data;
            if (hs && state == S_LEN_LO) n_words <= n_req[ADDR_WIDTH:0];
            if (hs && state == S_DATA_HI) hi <= rx_data;
            if (hs && state == S_DATA_LO) begin
                imem_wr_addr <= word_count[ADDR_WIDTH-1:0];
                imem_wr_data <= {hi, rx_data};
                word_count <= word_count + (ADDR_WIDTH+1)'(1);
            end
        end
    end

    loader_checksum u_csum (
        .clock(clock),
        .reset(reset),
        .clear(go),
        .en   (hs && state != S_CSUM),
        .data (rx_data),
        .match(match)
    );

    assign rx_ready = state inside {S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CSUM};
    assign busy = rx_ready;
    assign cpu_hold = state != S_RUN;
    assign done = state == S_RUN;
    assign error = state == S_ERROR;
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed frames with hand-computed writes and status checks
module tb_program_loader;
    logic clock = 0, reset = 1, start = 0, rx_valid = 0;
    logic [7:0] rx_data = 0;
    logic rx_ready, imem_wr_en, cpu_hold, busy, done, error;
    logic [7:0] imem_wr_addr;
    logic [15:0] imem_wr_data;
    logic [8:0] word_count;
    int n_checks = 0, n_fail = 0, strobes = 0, base = 0;
    logic [7:0] last_addr;
    logic [15:0] last_data;

    program_loader #(.ADDR_WIDTH(8)) dut (
        .clock(clock), .reset(reset), .start(start), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .imem_wr_en(imem_wr_en),
        .imem_wr_addr(imem_wr_addr), .imem_wr_data(imem_wr_data),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
        .word_count(word_count)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (imem_wr_en) begin
        strobes++;
        last_addr = imem_wr_addr;
        last_data = imem_wr_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap = 0);
        for (int g = 0; g < gap; g++) begin
            rx_valid = 0;
            @(posedge clock); #1;
        end
        rx_valid = 1;
        rx_data = b;
        @(posedge clock); #1;
        rx_valid = 0;
    endtask

    task automatic pulse_start();
        start = 1;
        @(posedge clock); #1;
        start = 0;
    endtask

    task automatic good_frame(input int gap);
        base = strobes;
        send(8'h00, gap); send(8'h02, gap); send(8'h12, gap);
        send(8'h34, gap);
        chk("w0_en", imem_wr_en, 1); chk("w0_addr", imem_wr_addr, 0); chk("w0_data", imem_wr_data, 16'h1234);
        send(8'hAB, gap);
        chk("w0_single", imem_wr_en, 0);
        send(8'hCD, gap);
        chk("w1_en", imem_wr_en, 1); chk("w1_addr", imem_wr_addr, 1); chk("w1_data", imem_wr_data, 16'hABCD);
        chk("csum_hold", cpu_hold, 1); chk("csum_busy", busy, 1);
        send(8'h42, gap);
        chk("good_hold", cpu_hold, 0); chk("good_done", done, 1); chk("good_busy", busy, 0);
        chk("good_ready", rx_ready, 0); chk("good_wc", word_count, 2); chk("good_strobes", strobes - base, 2);
    endtask

    initial begin
        #2;
        chk("rst_ready", rx_ready, 0); chk("rst_wr_en", imem_wr_en, 0); chk("rst_addr", imem_wr_addr, 0);
        chk("rst_data", imem_wr_data, 0); chk("rst_hold", cpu_hold, 1); chk("rst_busy", busy, 0);
        chk("rst_done", done, 0); chk("rst_error", error, 0); chk("rst_wc", word_count, 0);
        @(negedge clock) reset = 0;
        @(posedge clock); #1;
        send(8'h00);
        chk("idle_ignores_bytes", busy, 0);
        pulse_start();
        chk("start_busy", busy, 1); chk("start_ready", rx_ready, 1);
        good_frame(0);

        pulse_start();
        chk("reload_hold", cpu_hold, 1); chk("reload_busy", busy, 1); chk("reload_wc", word_count, 0);
        base = strobes;
        send(8'h00); send(8'h01); send(8'hFF); send(8'h00);
        chk("f2_en", imem_wr_en, 1); chk("f2_addr", imem_wr_addr, 0); chk("f2_data", imem_wr_data, 16'hFF00);
        send(8'hFE);
        chk("f2_done", done, 1); chk("f2_wc", word_count, 1); chk("f2_strobes", strobes - base, 1);

        pulse_start();
        base = strobes;
        send(8'h00); send(8'h02); send(8'h12); send(8'h34); send(8'hAB); send(8'hCD); send(8'h43);
        chk("bad_error", error, 1); chk("bad_hold", cpu_hold, 1); chk("bad_done", done, 0);
        chk("bad_strobes", strobes - base, 2); chk("bad_last", last_data, 16'hABCD);

        pulse_start();
        base = strobes;
        send(8'h00); send(8'h00);
        chk("len0_error", error, 1); chk("len0_busy", busy, 0);
        pulse_start();
        send(8'h01); send(8'h01);
        chk("len257_error", error, 1);
        @(posedge clock); #1;
        chk("badlen_strobes", strobes - base, 0);

        pulse_start();
        base = strobes;
        send(8'h01); send(8'h00);
        for (int i = 0; i < 256; i++) begin
            send(8'(i));
            send(~8'(i));
        end
        chk("full_addr", imem_wr_addr, 8'hFF); chk("full_data", imem_wr_data, 16'hFF00);
        chk("full_wc", word_count, 9'h100);
        send(8'h01);
        chk("full_done", done, 1); chk("full_strobes", strobes - base, 256);

        pulse_start();
        good_frame(1);

        pulse_start();
        base = strobes;
        send(8'h00); send(8'h02); send(8'h12);
        reset = 1;
        #1;
        chk("mid_rst_hold", cpu_hold, 1); chk("mid_rst_wc", word_count, 0);
        chk("mid_rst_busy", busy, 0); chk("mid_rst_done", done, 0);
        @(negedge clock) reset = 0;
        @(posedge clock); #1;
        chk("mid_rst_strobes", strobes - base, 0);
        pulse_start();
        good_frame(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/program_loader.md
# program_loader

Boot-time instruction loader for the pipelined CPU. It accepts a framed byte stream from a host link and assembles 16-bit instruction words. It writes those words into the instruction-memory write port and holds the CPU in reset until a complete, checksum-verified image has been loaded. It sits between the host/test link and the CPU's instruction memory and reset input, so it supplies what the CPU only consumes.

## Interface
- ADDR_WIDTH, 8, instruction-memory word-address width; capacity 2^ADDR_WIDTH words
- clock  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; one clock domain
- start  in  1  single-cycle request to begin a load; honoured only in IDLE, RUN and ERROR
- rx_data  in  8  stream byte from the host
- rx_valid  in  1  rx_data is valid
- rx_ready  out  1  loader accepts a byte; a byte transfers when rx_valid && rx_ready at a rising edge
- imem_wr_en  out  1  single-cycle instruction-memory write strobe
- imem_wr_addr  out  ADDR_WIDTH  word address being written
- imem_wr_data  out  16  instruction word, {high byte, low byte}
- cpu_hold  out  1  1 = keep the CPU in reset; integration adapts the polarity to the CPU reset pin
- busy  out  1  a load frame is in progress
- done  out  1  image loaded and verified; CPU released
- error  out  1  last frame rejected
- word_count  out  ADDR_WIDTH+1  words written in the current or last frame

## Operation
- Frame format: LEN_HI, LEN_LO (N words, big-endian), then 2N instruction bytes (high byte first), then CSUM. CSUM is the XOR of every preceding frame byte, length bytes included.
- States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM, RUN, ERROR.
- IDLE: start -> LEN_HI. Clear word_count and the checksum accumulator.
- LEN_HI -> LEN_LO on handshake.
- LEN_LO on handshake:
  - N == 0 or N > 2^ADDR_WIDTH -> ERROR.
  - Otherwise -> DATA_HI.
- DATA_HI: latch the byte as the high byte -> DATA_LO.
- DATA_LO on handshake:
  - Schedule a write of {hi, byte} to address word_count.
  - Increment word_count.
  - Go to CSUM if word_count+1 == N, otherwise DATA_HI.
- CSUM on handshake: byte == accumulator -> RUN; otherwise -> ERROR.
- RUN: start -> LEN_HI and reload; word_count and the accumulator clear.
- ERROR: start -> LEN_HI and retry.
- start is ignored in LEN_HI..CSUM.
- Moore outputs:
  - rx_ready = 1 in LEN_HI..CSUM.
  - busy = 1 in LEN_HI..CSUM.
  - cpu_hold = 0 only in RUN.
  - done = 1 only in RUN.
  - error = 1 only in ERROR.
- Words written before a checksum failure remain in memory. The CPU stays held.
- Addresses written: 0 .. N-1 only. No wrap; oversize lengths are rejected at LEN_LO.

## Timing
- Reset values: state IDLE, rx_ready=0, imem_wr_en=0, imem_wr_addr=0, imem_wr_data=0, cpu_hold=1, busy=0, done=0, error=0, word_count=0, accumulator=0.
- Reset mid-frame returns to IDLE immediately (asynchronously). No further write strobes occur.
- Write latency: imem_wr_en is high for exactly one cycle, the cycle after the DATA_LO handshake. imem_wr_addr and imem_wr_data are registered and valid in that same cycle.
- The final word's write strobe coincides with the first cycle of CSUM.
- cpu_hold falls one cycle after the CSUM handshake.
- On start in RUN, cpu_hold rises one cycle after start.
- Back-pressure: rx_ready never depends on rx_valid. A stalled host (rx_valid=0) freezes state with no side effects.
- Throughput: one byte per cycle, so one word is written every 2 cycles at full rate.

## Structure
- Shared package (loader_pkg) holds:
  - state enum
  - WORD_WIDTH=16
  - header length of 2 bytes
  - CSUM_INIT=8'h00
- One natural sub-module, loader_checksum, containing:
  - 8-bit XOR accumulator
  - clear input
  - byte-enable input
  - match output comparing the incoming byte to the accumulator

## Test plan
- Good frame 00 02 12 34 AB CD 42, one byte per cycle -> writes (0, 1234) then (1, ABCD). cpu_hold falls one cycle after byte 42. done=1, word_count=2.
- Same frame, last byte 43 -> both words written. error=1, cpu_hold stays 1, done=0.
- Length 00 00, and with ADDR_WIDTH=8 length 01 01 -> ERROR after LEN_LO, no imem_wr_en pulse.
- Good frame with rx_valid toggled 0/1 every other cycle -> identical writes and final state, no duplicate strobes.
- Assert reset after 3 bytes of a good frame -> IDLE immediately, cpu_hold=1, word_count=0. The following start plus the full frame loads correctly.
- From RUN, pulse start -> cpu_hold=1 and busy=1 next cycle. A second frame 00 01 FF 00 FE writes (0, FF00) and returns to RUN.
